// File: rtl/mul_div_unit.sv
// MIPS E-stage multiply/divide unit: HI/LO registers plus MULT/DIV results that commit MULT_CYCLES/DIV_CYCLES edges after the start edge.
// No backpressure: ops arriving while busy are dropped, and md_active lets the hazard logic stall before that can happen.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_active,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_hi, r_lo, r_p_hi, r_p_lo;
    logic [31:0]      w_hi_nxt, w_lo_nxt, w_p_hi_nxt, w_p_lo_nxt;
    logic             r_busy;

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_ovf;
    logic [31:0]        w_divs_b, w_divu_b;
    logic signed [31:0] w_sa, w_sb, w_q_s, w_r_s;
    logic [31:0]        w_q_u, w_r_u;
    logic               w_is_md;

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // A zero or overflowing divisor is replaced by 1 so the dividers never see it;
    // for the most-negative / -1 case that yields exactly quotient 0x80000000, remainder 0.
    assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_divs_b  = ((B == 32'd0) || w_div_ovf) ? 32'd1 : B;
    assign w_divu_b  = (B == 32'd0) ? 32'd1 : B;
    assign w_sa      = $signed(A);
    assign w_sb      = $signed(w_divs_b);
    assign w_q_s     = w_sa / w_sb;
    assign w_r_s     = w_sa % w_sb;
    assign w_q_u     = A / w_divu_b;
    assign w_r_u     = A % w_divu_b;

    assign w_is_md   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign md_active = r_busy || (start && w_is_md);
    assign busy      = r_busy;
    assign HI        = r_hi;
    assign LO        = r_lo;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            w_p_hi_nxt  = w_prod_s[63:32];
                            w_p_lo_nxt  = w_prod_s[31:0];
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_RUN;
                        end
                        OP_MULTU: begin
                            w_p_hi_nxt  = w_prod_u[63:32];
                            w_p_lo_nxt  = w_prod_u[31:0];
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_RUN;
                        end
                        OP_DIV: begin
                            if (B != 32'd0) begin
                                w_p_hi_nxt  = w_r_s;
                                w_p_lo_nxt  = w_q_s;
                                w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                                w_state_nxt = S_RUN;
                            end
                        end
                        OP_DIVU: begin
                            if (B != 32'd0) begin
                                w_p_hi_nxt  = w_r_u;
                                w_p_lo_nxt  = w_q_u;
                                w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                                w_state_nxt = S_RUN;
                            end
                        end
                        OP_MTHI: w_hi_nxt = A;
                        OP_MTLO: w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_hi_nxt    = r_p_hi;
                    w_lo_nxt    = r_p_lo;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_cnt_nxt != '0);
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table of single ops plus sequences for ops during RUN and reset mid-op.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, md_active;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .md_active(md_active), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_md, input string nm);
        op = o; A = a; B = b; start = 1'b1;
        #1;
        check({nm, " md_active"}, {63'd0, md_active}, {63'd0, exp_md});
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        A = $urandom; B = $urandom;
    endtask

    // Counts busy cycles (bounded) and requires HI/LO to hold their old values while busy.
    task automatic wait_done(output int n, input logic [31:0] hi_old, input logic [31:0] lo_old,
                             input string nm);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            check({nm, " hold"}, {HI, LO}, {hi_old, lo_old});
        end
    endtask

    vec_t vecs[15];
    int   n;
    logic [31:0] ph, pl;

    initial begin
        vecs[0]  = '{"mult_neg",   3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        vecs[1]  = '{"multu",      3'd2, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 5};
        vecs[2]  = '{"div_neg",    3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{"divu",       3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4]  = '{"div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[5]  = '{"mthi",       3'd5, 32'h11,        32'd0,         32'h11,        32'h8000_0000, 0};
        vecs[6]  = '{"mtlo",       3'd6, 32'h22,        32'd0,         32'h11,        32'h22,        0};
        vecs[7]  = '{"div_zero",   3'd3, 32'd5,         32'd0,         32'h11,        32'h22,        0};
        vecs[8]  = '{"divu_zero",  3'd4, 32'd5,         32'd0,         32'h11,        32'h22,        0};
        vecs[9]  = '{"mult_max",   3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[10] = '{"div_negb",   3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[11] = '{"divu_big",   3'd4, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 10};
        vecs[12] = '{"mtlo_1234",  3'd6, 32'h1234,      32'd0,         32'hF,         32'h1234,      0};
        vecs[13] = '{"multu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[14] = '{"reserved",   3'd7, 32'hDEAD,      32'hBEEF,      32'hFFFF_FFFE, 32'h0000_0001, 0};

        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        check("reset_state", {HI, LO}, 64'd0);
        check("reset_busy", {62'd0, busy, md_active}, 64'd0);

        ph = 32'd0; pl = 32'd0;
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b,
                  (vecs[i].op >= 3'd1 && vecs[i].op <= 3'd4), vecs[i].name);
            wait_done(n, ph, pl, vecs[i].name);
            check({vecs[i].name, " cycles"}, 64'(n), 64'(vecs[i].cycles));
            check({vecs[i].name, " hilo"}, {HI, LO}, {vecs[i].hi, vecs[i].lo});
            check({vecs[i].name, " md_idle"}, {63'd0, md_active}, 64'd0);
            ph = vecs[i].hi; pl = vecs[i].lo;
            @(posedge clk); #1;
        end

        // MTHI arriving on the second busy cycle of a MULT must be dropped.
        issue(3'd1, 32'd2, 32'd3, 1'b1, "run_mult");
        @(posedge clk); #1;
        issue(3'd5, 32'hABCD, 32'd0, 1'b1, "run_mthi");
        check("run_mthi_hi", {32'd0, HI}, {32'd0, ph});
        wait_done(n, ph, pl, "run_mult");
        check("run_mult cycles", 64'(n), 64'd3);
        check("run_mult hilo", {HI, LO}, {32'd0, 32'd6});
        @(posedge clk); #1;

        // Reset on busy cycle 4 of a DIVU discards the pending 14/2.
        issue(3'd4, 32'd100, 32'd7, 1'b1, "rst_divu");
        repeat (3) begin @(posedge clk); #1; end
        check("rst_divu busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_divu hilo", {HI, LO}, 64'd0);
        check("rst_divu flags", {62'd0, busy, md_active}, 64'd0);
        repeat (15) @(posedge clk);
        #1;
        check("rst_divu late_hilo", {HI, LO}, 64'd0);
        check("rst_divu late_busy", {63'd0, busy}, 64'd0);

        // Two-cycle reset mid-stream after loading HI/LO.
        issue(3'd5, 32'h55, 32'd0, 1'b0, "pre_mthi");
        issue(3'd6, 32'h66, 32'd0, 1'b0, "pre_mtlo");
        check("pre_rst hilo", {HI, LO}, {32'h55, 32'h66});
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        check("rst2 hilo", {HI, LO}, 64'd0);
        check("rst2 flags", {62'd0, busy, md_active}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the execute (E) stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and models the fixed multiply/divide latency.
- Exports busy status to the hazard/stall logic directly downstream, which uses it to stall MFHI/MFLO/MULT/DIV/MTHI/MTLO in D.
- HI/LO values are read combinationally by the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles after a MULT/MULTU start (>=1).
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU start (>=1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is an MDU op this cycle.
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  registered; high while a multiply/divide is in flight.
- md_active  output  1  combinational: busy OR (start AND op is MULT/MULTU/DIV/DIVU). Feeds the hazard stall term.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset values:
  - On a clk edge with reset=1: HI=0, LO=0, busy=0, counter=0, pending result=0.
  - Reset overrides everything, including an in-flight operation; the pending result is discarded.
- Internal state:
  - Counter cnt (CNT_W bits).
  - Pending registers P_HI and P_LO (32 bits each).
  - busy is registered and equals (cnt != 0) after each edge.
- States:
  - IDLE (cnt==0) and RUN (cnt!=0); no other states.
- IDLE transitions, on an edge with start=1:
  - MULT: {P_HI,P_LO} = signed(A)*signed(B), full 64-bit product; cnt=MULT_CYCLES; go RUN.
  - MULTU: same as MULT, unsigned 64-bit product.
  - DIV: P_LO = signed quotient truncated toward zero; P_HI = remainder with the sign of A; cnt=DIV_CYCLES; go RUN.
  - DIVU: unsigned quotient and remainder; cnt=DIV_CYCLES; go RUN.
  - DIV/DIVU with B==0: no operation and no state change; stay IDLE; busy stays 0; HI/LO unchanged.
  - Special case DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - MTHI: HI<=A at this edge; stay IDLE.
  - MTLO: LO<=A at this edge; stay IDLE.
  - NONE/reserved, or start=0: no change.
- RUN transitions, each edge:
  - cnt decrements by 1.
  - On the edge where cnt goes 1->0: HI<=P_HI, LO<=P_LO, busy drops.
  - Result: busy is high for exactly N consecutive cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO values are visible in the first cycle busy is low.
- start during RUN:
  - All ops ignored, including MTHI/MTLO; HI/LO are not written early.
  - The hazard logic guarantees this never happens; the unit must still be safe.
- HI/LO during RUN: keep their old values until completion.
- Arithmetic: products/quotients are computed from the operands sampled at the start edge; later changes to A/B have no effect.
- md_active: asserted in the start cycle itself, so a dependent MFHI in D stalls with no bubble gap.

Test Plan:
- Reset: assert reset 2 cycles mid-stream -> HI=LO=0, busy=0, md_active=0 on the following cycle.
- MULT, A=0xFFFFFFFD (-3), B=5:
  - busy=1 for exactly 5 cycles; HI/LO unchanged while busy.
  - When busy falls: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - MULTU with the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV, A=0xFFFFFFF9 (-7), B=2:
  - busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 -> LO=3, HI=1.
- Divide by zero: HI=0x11, LO=0x22, then DIV with B=0 -> busy stays 0; HI/LO remain 0x11/0x22.
- Start during RUN: MULT 2*3, then MTHI A=0xABCD on cycle 2 of busy -> MTHI ignored; after completion HI=0, LO=6.
- Reset mid-op: DIVU 100/7, reset on busy cycle 4 -> HI=LO=0, busy=0; no later write of 14/2.
- MTLO: A=0x1234 in IDLE -> LO=0x1234 the next cycle; busy never rises; md_active=0.
